// File: rtl/core_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// core_sequencer
//
// Multi-cycle control FSM that fetches, decodes and retires one 16-bit
// instruction at a time. It steers an external 16x16 register bank, whose r15
// is the instruction pointer (IP). The bank advances IP by 2 on every Enable,
// or by TargetIn when Jump is set. The sequencer also owns the single shared
// memory port, which it uses for instruction fetch, load and store through a
// request/ready handshake.
//
// Instruction format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2
//   0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR : rd <= rs1 op rs2 (16-bit wrap-around)
//   5 LDI : rd <= sext(IR[7:0])
//   6 LD  : rd <= mem[R[rs1]]
//   7 ST  : mem[R[rs1]] <= R[rs2]
//   8 BEQ : if R[rs1] == R[rs2] then IP += sext(IR[11:8]) << 1, else IP += 2
//   F HALT; all other opcodes are handled according to ILLEGAL_HALT.
//
// Ports
//   clk, rst_n              clock (rising edge), async active-low reset
//   run_i                   level; while high the sequencer keeps fetching
//   halted_o                high while in HALT
//   retired_o               one-cycle pulse per retired instruction
//   bank_enable_o           bank Enable (IP update strobe)
//   source1/2_address_o     bank read addresses (IR[7:4], IR[3:0])
//   target_address_o        bank write address (IR[11:8])
//   target_write_enable_o   bank write strobe
//   target_in_o             bank write data, or branch offset when jump_o is set
//   jump_o                  bank Jump (taken BEQ only)
//   source1/2_out_i         bank read data (combinational)
//   instruction_pointer_i   bank r15
//   mem_request_o           memory request
//   mem_write_o             1 = store, 0 = read
//   mem_address_o           byte address
//   mem_write_data_o        store data
//   mem_ready_i             completes a request on a clk edge with mem_request_o
//   mem_read_data_i         read data, valid together with mem_ready_i
//
// Parameters
//   ILLEGAL_HALT            1: undefined opcodes halt; 0: they retire as NOP
// -----------------------------------------------------------------------------
module core_sequencer #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_i,
  output logic        halted_o,
  output logic        retired_o,
  output logic        bank_enable_o,
  output logic [3:0]  source1_address_o,
  output logic [3:0]  source2_address_o,
  output logic [3:0]  target_address_o,
  output logic        target_write_enable_o,
  output logic [15:0] target_in_o,
  output logic        jump_o,
  input  logic [15:0] source1_out_i,
  input  logic [15:0] source2_out_i,
  input  logic [15:0] instruction_pointer_i,
  output logic        mem_request_o,
  output logic        mem_write_o,
  output logic [15:0] mem_address_o,
  output logic [15:0] mem_write_data_o,
  input  logic        mem_ready_i,
  input  logic [15:0] mem_read_data_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXECUTE,
    S_MEMORY,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_LDI  = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_BEQ  = 4'h8,
    OP_HALT = 4'hF
  } opcode_e;

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] mem_addr_q, mem_addr_d;    // LD/ST address captured in EXECUTE
  logic [15:0] mem_wdata_q, mem_wdata_d;  // ST data captured in EXECUTE

  // NOTE: IR and the latched address/data are cleared with the state so that
  // every output reads 0 as soon as rst_n falls, with no dependence on clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ir_q        <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking updates, so every flop samples pre-edge values
      // regardless of the order the simulator evaluates these statements.
      state_q     <= state_d;
      ir_q        <= ir_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  opcode_e     op;
  logic        rd_is_ip;
  logic [15:0] ldi_imm;
  logic [15:0] branch_offset;
  logic [15:0] alu_result;
  logic        operands_equal;
  state_e      after_retire;

  assign op                = opcode_e'(ir_q[15:12]);
  assign source1_address_o = ir_q[7:4];
  assign source2_address_o = ir_q[3:0];
  assign target_address_o  = ir_q[11:8];

  // r15 is the IP; writing it would fight the bank's own IP update.
  assign rd_is_ip       = (ir_q[11:8] == 4'hF);
  assign ldi_imm        = {{8{ir_q[7]}}, ir_q[7:0]};
  // BEQ reuses the rd field as a signed word offset, scaled to bytes.
  assign branch_offset  = {{11{ir_q[11]}}, ir_q[11:8], 1'b0};
  assign operands_equal = (source1_out_i == source2_out_i);
  assign after_retire   = run_i ? S_FETCH : S_IDLE;

  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = source1_out_i + source2_out_i;
      OP_SUB:  alu_result = source1_out_i - source2_out_i;
      OP_AND:  alu_result = source1_out_i & source2_out_i;
      OP_OR:   alu_result = source1_out_i | source2_out_i;
      OP_XOR:  alu_result = source1_out_i ^ source2_out_i;
      default: alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written below gets a default first, so no branch of
    // the case can leave one unassigned and infer a latch.
    state_d               = state_q;
    ir_d                  = ir_q;
    mem_addr_d            = mem_addr_q;
    mem_wdata_d           = mem_wdata_q;
    bank_enable_o         = 1'b0;
    target_write_enable_o = 1'b0;
    target_in_o           = '0;
    jump_o                = 1'b0;
    mem_request_o         = 1'b0;
    mem_write_o           = 1'b0;
    mem_address_o         = '0;
    mem_write_data_o      = '0;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end

      // IP only moves on bank Enable, so the fetch address is stable for the
      // whole request without needing a latch of its own.
      S_FETCH: begin
        mem_request_o = 1'b1;
        mem_address_o = instruction_pointer_i;
        if (mem_ready_i) begin
          ir_d    = mem_read_data_i;
          state_d = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
            bank_enable_o         = 1'b1;
            target_in_o           = alu_result;
            target_write_enable_o = !rd_is_ip;
            state_d               = after_retire;
          end
          OP_LDI: begin
            bank_enable_o         = 1'b1;
            target_in_o           = ldi_imm;
            target_write_enable_o = !rd_is_ip;
            state_d               = after_retire;
          end
          // Operands are captured here so the memory request stays stable
          // even though the bank read ports are combinational.
          OP_LD, OP_ST: begin
            mem_addr_d  = source1_out_i;
            mem_wdata_d = source2_out_i;
            state_d     = S_MEMORY;
          end
          OP_BEQ: begin
            bank_enable_o = 1'b1;
            if (operands_equal) begin
              jump_o      = 1'b1;
              target_in_o = branch_offset;
            end
            state_d = after_retire;
          end
          // No retire: IP keeps pointing at the HALT instruction.
          OP_HALT: begin
            state_d = S_HALT;
          end
          default: begin
            if (ILLEGAL_HALT) begin
              state_d = S_HALT;
            end else begin
              bank_enable_o = 1'b1;
              state_d       = after_retire;
            end
          end
        endcase
      end

      S_MEMORY: begin
        mem_request_o    = 1'b1;
        mem_write_o      = (op == OP_ST);
        mem_address_o    = mem_addr_q;
        mem_write_data_o = mem_wdata_q;
        if (mem_ready_i) begin
          bank_enable_o = 1'b1;
          if (op == OP_LD) begin
            target_in_o           = mem_read_data_i;
            target_write_enable_o = !rd_is_ip;
          end
          state_d = after_retire;
        end
      end

      // Absorbing: only rst_n leaves HALT.
      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign retired_o = bank_enable_o;
  assign halted_o  = (state_q == S_HALT);

endmodule

// File: tb/tb_core_sequencer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_core_sequencer
//
// Drives core_sequencer with a behavioural register bank and a memory with
// a programmable number of wait cycles. Directed programs are loaded into
// memory; the expected retire records (IP, write strobe, rd, data, jump,
// cycle gap) and store beats are pushed into queues up front, and monitor
// processes pop and compare them whenever the DUT retires or stores.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  localparam int CLK_HALF = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        halted, retired, bank_enable;
  logic [3:0]  source1_address, source2_address, target_address;
  logic        target_write_enable;
  logic [15:0] target_in;
  logic        jump;
  logic [15:0] source1_out, source2_out, instruction_pointer;
  logic        mem_request, mem_write;
  logic [15:0] mem_address, mem_write_data;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_read_data = '0;

  always #CLK_HALF clk = ~clk;

  core_sequencer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .run_i                 (run),
    .halted_o              (halted),
    .retired_o             (retired),
    .bank_enable_o         (bank_enable),
    .source1_address_o     (source1_address),
    .source2_address_o     (source2_address),
    .target_address_o      (target_address),
    .target_write_enable_o (target_write_enable),
    .target_in_o           (target_in),
    .jump_o                (jump),
    .source1_out_i         (source1_out),
    .source2_out_i         (source2_out),
    .instruction_pointer_i (instruction_pointer),
    .mem_request_o         (mem_request),
    .mem_write_o           (mem_write),
    .mem_address_o         (mem_address),
    .mem_write_data_o      (mem_write_data),
    .mem_ready_i           (mem_ready),
    .mem_read_data_i       (mem_read_data)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int num_checks = 0;
  int num_errors = 0;
  int cycle = 0;
  int last_retire = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name, input string what);
    num_checks++;
    num_errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  always @(posedge clk) cycle++;

  // ---------------------------------------------------------------------------
  // Register bank model: r15 is IP, r0 writes are dropped, sync reset
  // ---------------------------------------------------------------------------
  logic [15:0] regs [16];

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (bank_enable) begin
      if (target_write_enable && target_address != 4'd0) regs[target_address] <= target_in;
      regs[15] <= jump ? regs[15] + target_in : regs[15] + 16'd2;
    end
  end

  assign source1_out         = regs[source1_address];
  assign source2_out         = regs[source2_address];
  assign instruction_pointer = regs[15];

  // ---------------------------------------------------------------------------
  // Memory model with wait_cfg wait cycles per request. Inputs change 1 ns
  // after the rising edge; the held request is compared on every wait cycle.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] data;
  } store_t;

  logic [15:0] mem [1024];
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  logic [32:0] held_req;
  store_t      exp_store_q[$];
  store_t      exp_store;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
    end else begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        wait_cnt  = 0;
      end
      if (mem_request) begin
        if (wait_cnt == 0) held_req = {mem_write, mem_address, mem_write_data};
        else check("req_stable", {mem_write, mem_address, mem_write_data}, held_req);
        if (wait_cnt >= wait_cfg) begin
          mem_ready     = 1'b1;
          mem_read_data = mem[mem_address[10:1]];
          if (mem_write) begin
            if (exp_store_q.size() == 0) begin
              fail("store_beat", $sformatf("unexpected store 0x%0h -> 0x%0h", mem_write_data, mem_address));
            end else begin
              exp_store = exp_store_q.pop_front();
              check("store_addr", mem_address, exp_store.addr);
              check("store_data", mem_write_data, exp_store.data);
            end
            mem[mem_address[10:1]] = mem_write_data;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Retire scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [15:0] ip;
    logic        we;
    logic [3:0]  rd;
    logic [15:0] data;
    logic        jump;
    logic [7:0]  gap;   // cycles since previous retire, 0 = not checked
  } retire_t;

  retire_t exp_q[$];
  retire_t exp_r;

  task automatic expect_retire(input logic [15:0] ip, input logic we, input logic [3:0] rd,
                               input logic [15:0] data, input logic jmp, input int gap);
    exp_q.push_back('{ip: ip, we: we, rd: rd, data: data, jump: jmp, gap: 8'(gap)});
  endtask

  always @(negedge clk) begin
    if (rst_n && (jump || target_write_enable)) check("strobe_needs_enable", bank_enable, 1'b1);
    if (rst_n && retired) begin
      check("retired_eq_enable", retired, bank_enable);
      if (exp_q.size() == 0) begin
        fail("retire", $sformatf("unexpected retire at IP 0x%0h", instruction_pointer));
      end else begin
        exp_r = exp_q.pop_front();
        check("retire_ip", instruction_pointer, exp_r.ip);
        check("retire_we", target_write_enable, exp_r.we);
        check("retire_jump", jump, exp_r.jump);
        if (exp_r.we) check("retire_rd", target_address, exp_r.rd);
        if (exp_r.we || exp_r.jump) check("retire_data", target_in, exp_r.data);
        if (exp_r.gap != 0) check("retire_gap", cycle - last_retire, exp_r.gap);
      end
      last_retire = cycle;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic load(input int addr, input logic [15:0] word);
    mem[addr >> 1] = word;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ctrl"}, {halted, retired, bank_enable, target_write_enable, jump, mem_request,
                           mem_write, source1_address, source2_address, target_address}, '0);
    check({tag, "_data"}, {target_in, mem_address, mem_write_data}, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
  endtask

  // Run until HALT (bounded), then confirm HALT is absorbing and quiet.
  task automatic finish_phase(input string tag, input logic [15:0] exp_ip);
    int n;
    n = 0;
    while (!halted && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halted"}, halted, 1'b1);
    check({tag, "_halt_ip"}, instruction_pointer, exp_ip);
    repeat (4) begin
      @(negedge clk);
      check({tag, "_halt_no_request"}, {mem_request, bank_enable}, '0);
    end
    check({tag, "_halt_ip_held"}, instruction_pointer, exp_ip);
    check({tag, "_retires_drained"}, exp_q.size(), 0);
    check({tag, "_stores_drained"}, exp_store_q.size(), 0);
    run = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed phases
  // ---------------------------------------------------------------------------
  initial begin
    int n;

    // Phase A: zero-wait ALU / LDI / LD / ST program
    wait_cfg = 0;
    clear_mem();
    load(16'h00, 16'h5105); expect_retire(16'h00, 1, 4'd1,  16'h0005, 0, 0); // LDI r1,5
    load(16'h02, 16'h52FD); expect_retire(16'h02, 1, 4'd2,  16'hFFFD, 0, 2); // LDI r2,-3
    load(16'h04, 16'h0312); expect_retire(16'h04, 1, 4'd3,  16'h0002, 0, 2); // ADD r3,r1,r2
    load(16'h06, 16'h5203); expect_retire(16'h06, 1, 4'd2,  16'h0003, 0, 2); // LDI r2,3
    load(16'h08, 16'h1421); expect_retire(16'h08, 1, 4'd4,  16'hFFFE, 0, 2); // SUB r4,r2,r1
    load(16'h0A, 16'h5740); expect_retire(16'h0A, 1, 4'd7,  16'h0040, 0, 2); // LDI r7,0x40
    load(16'h0C, 16'h6670); expect_retire(16'h0C, 1, 4'd6,  16'hF0F0, 0, 3); // LD r6,[r7]
    load(16'h0E, 16'h5742); expect_retire(16'h0E, 1, 4'd7,  16'h0042, 0, 2); // LDI r7,0x42
    load(16'h10, 16'h6870); expect_retire(16'h10, 1, 4'd8,  16'h0FF0, 0, 3); // LD r8,[r7]
    load(16'h12, 16'h2968); expect_retire(16'h12, 1, 4'd9,  16'h00F0, 0, 2); // AND r9,r6,r8
    load(16'h14, 16'h3A68); expect_retire(16'h14, 1, 4'd10, 16'hFFF0, 0, 2); // OR r10,r6,r8
    load(16'h16, 16'h4B68); expect_retire(16'h16, 1, 4'd11, 16'hFF00, 0, 2); // XOR r11,r6,r8
    load(16'h18, 16'h5744); expect_retire(16'h18, 1, 4'd7,  16'h0044, 0, 2); // LDI r7,0x44
    load(16'h1A, 16'h6C70); expect_retire(16'h1A, 1, 4'd12, 16'h0200, 0, 3); // LD r12,[r7]
    load(16'h1C, 16'h5746); expect_retire(16'h1C, 1, 4'd7,  16'h0046, 0, 2); // LDI r7,0x46
    load(16'h1E, 16'h6D70); expect_retire(16'h1E, 1, 4'd13, 16'h1234, 0, 3); // LD r13,[r7]
    load(16'h20, 16'h70CD); expect_retire(16'h20, 0, 4'd0,  16'h0000, 0, 3); // ST [r12],r13
    exp_store_q.push_back('{addr: 16'h0200, data: 16'h1234});
    load(16'h22, 16'hF000);                                                  // HALT
    load(16'h40, 16'hF0F0);
    load(16'h42, 16'h0FF0);
    load(16'h44, 16'h0200);
    load(16'h46, 16'h1234);
    do_reset();
    run = 1'b1;
    finish_phase("alu_mem", 16'h0022);
    check("store_landed", mem[16'h0200 >> 1], 16'h1234);

    // Phase B: three wait cycles on every access
    wait_cfg = 3;
    clear_mem();
    load(16'h00, 16'h5140); expect_retire(16'h00, 1, 4'd1, 16'h0040, 0, 0); // LDI r1,0x40
    load(16'h02, 16'h0111); expect_retire(16'h02, 1, 4'd1, 16'h0080, 0, 5); // ADD r1,r1,r1
    load(16'h04, 16'h0111); expect_retire(16'h04, 1, 4'd1, 16'h0100, 0, 5); // ADD r1,r1,r1
    load(16'h06, 16'h6510); expect_retire(16'h06, 1, 4'd5, 16'hBEEF, 0, 9); // LD r5,[r1]
    load(16'h08, 16'hF000);
    load(16'h100, 16'hBEEF);
    do_reset();
    run = 1'b1;
    finish_phase("wait_states", 16'h0008);

    // Phase C: reset while the LD data request is waiting
    wait_cfg = 20;
    clear_mem();
    load(16'h00, 16'h5120); expect_retire(16'h00, 1, 4'd1, 16'h0020, 0, 0); // LDI r1,0x20
    load(16'h02, 16'h6210);                                                  // LD r2,[r1]
    load(16'h04, 16'hF000);
    load(16'h20, 16'hAAAA);
    do_reset();
    run = 1'b1;
    n = 0;
    while (!(mem_request && !mem_write && mem_address == 16'h0020) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      fail("ld_request_seen", "LD data request never issued");
    end else begin
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("async_reset");
    end
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("retires_before_reset", exp_q.size(), 0);
    repeat (3) begin
      @(negedge clk);
      check("idle_after_reset", {mem_request, halted, bank_enable}, '0);
    end
    wait_cfg = 0;
    expect_retire(16'h00, 1, 4'd1, 16'h0020, 0, 0);
    expect_retire(16'h02, 1, 4'd2, 16'hAAAA, 0, 3);
    run = 1'b1;
    @(negedge clk);
    check("refetch_from_zero", {mem_request, mem_address}, {1'b1, 16'h0000});
    finish_phase("reset_abort", 16'h0004);

    // Phase D: branches, illegal opcode as NOP, rd = r15 suppression
    wait_cfg = 0;
    clear_mem();
    load(16'h00, 16'h5101); expect_retire(16'h00, 1, 4'd1, 16'h0001, 0, 0); // LDI r1,1
    load(16'h02, 16'h5401); expect_retire(16'h02, 1, 4'd4, 16'h0001, 0, 2); // LDI r4,1
    load(16'h04, 16'h8314); expect_retire(16'h04, 0, 4'd0, 16'h0006, 1, 2); // BEQ r1,r4,+6
    load(16'h06, 16'hF000);
    load(16'h08, 16'hF000);
    load(16'h0A, 16'h9000); expect_retire(16'h0A, 0, 4'd0, 16'h0000, 0, 2); // undefined -> NOP
    load(16'h0C, 16'h5307); expect_retire(16'h0C, 1, 4'd3, 16'h0007, 0, 2); // LDI r3,7
    load(16'h0E, 16'h0224); expect_retire(16'h0E, 1, 4'd2, 16'h0001, 0, 2); // ADD r2,r2,r4
    load(16'h10, 16'h8E12); expect_retire(16'h10, 0, 4'd0, 16'hFFFC, 1, 2); // BEQ taken, -2
                            expect_retire(16'h0C, 1, 4'd3, 16'h0007, 0, 2);
                            expect_retire(16'h0E, 1, 4'd2, 16'h0002, 0, 2);
                            expect_retire(16'h10, 0, 4'd0, 16'h0000, 0, 2); // BEQ not taken
    load(16'h12, 16'h5F11); expect_retire(16'h12, 0, 4'd0, 16'h0000, 0, 2); // LDI r15 dropped
    load(16'h14, 16'hF000);
    do_reset();
    run = 1'b1;
    finish_phase("branch", 16'h0014);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
